// File: rtl/fpu_lzd_pipe.sv
// Two-stage pipelined leading-one detector / normaliser with valid-ready handshakes.
// S1 holds the operand and per-nibble encodings; S2 holds the merged position, count and shifted operand.
module fpu_lzd_pipe #(
    parameter int WIDTH = 32,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic [POS_W:0]   out_lzc,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    localparam int NG = WIDTH / 4;
    localparam int LV = $clog2(NG);

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0 || POS_W < $clog2(WIDTH)) begin : g_bad_param
        $error("fpu_lzd_pipe: WIDTH must be a power of two in 4..64 and POS_W >= clog2(WIDTH)");
    end

    typedef enum logic {EMPTY, FULL} stage_e;

    stage_e s1_st_q, s1_st_d;
    stage_e s2_st_q, s2_st_d;

    logic [WIDTH-1:0] s1_data_q;
    logic [NG-1:0]    s1_gv_q, gv_d;
    logic [1:0]       s1_gp_q [NG];
    logic [1:0]       gp_d    [NG];

    logic [POS_W-1:0] s2_pos_q, pos_d;
    logic [POS_W:0]   s2_lzc_q, lzc_d;
    logic             s2_zero_q, zero_d;
    logic [WIDTH-1:0] s2_norm_q, norm_d;

    logic             tv [LV+1][NG];
    logic [POS_W-1:0] tp [LV+1][NG];

    logic s2_can_accept, s1_adv, in_fire;

    assign s2_can_accept = (s2_st_q == EMPTY) || out_ready;
    assign s1_adv        = (s1_st_q == FULL) && s2_can_accept;
    assign in_ready      = (s1_st_q == EMPTY) || s2_can_accept;
    assign in_fire       = in_valid && in_ready;

    always_comb begin
        s1_st_d = s1_st_q;
        s2_st_d = s2_st_q;
        case (s1_st_q)
            EMPTY:   if (in_fire) s1_st_d = FULL;
            FULL:    if (s1_adv && !in_fire) s1_st_d = EMPTY;
            default: s1_st_d = EMPTY;
        endcase
        case (s2_st_q)
            EMPTY:   if (s1_adv) s2_st_d = FULL;
            FULL:    if (out_ready && !s1_adv) s2_st_d = EMPTY;
            default: s2_st_d = EMPTY;
        endcase
    end

    // Per-nibble presence flag and local index of the highest set bit.
    always_comb begin
        gv_d = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            gv_d[g] = |in_data[4*g +: 4];
            gp_d[g] = in_data[4*g+3] ? 2'd3 :
                      in_data[4*g+2] ? 2'd2 :
                      in_data[4*g+1] ? 2'd1 : 2'd0;
        end
    end

    // Pairwise merge: each level adds one position bit, upper child wins when it has a set bit.
    always_comb begin
        for (int unsigned k = 0; k <= LV; k++) begin
            for (int unsigned i = 0; i < NG; i++) begin
                tv[k][i] = 1'b0;
                tp[k][i] = '0;
            end
        end
        for (int unsigned i = 0; i < NG; i++) begin
            tv[0][i]      = s1_gv_q[i];
            tp[0][i][1:0] = s1_gp_q[i];
        end
        for (int unsigned k = 0; k < LV; k++) begin
            for (int unsigned i = 0; i < (NG >> (k + 1)); i++) begin
                tv[k+1][i] = tv[k][2*i+1] | tv[k][2*i];
                tp[k+1][i] = tv[k][2*i+1] ? (tp[k][2*i+1] | (POS_W'(1) << (k + 2)))
                                          : tp[k][2*i];
            end
        end
    end

    always_comb begin
        zero_d = !tv[LV][0];
        pos_d  = zero_d ? '0 : tp[LV][0];
        lzc_d  = zero_d ? (POS_W+1)'(WIDTH)
                        : (POS_W+1)'(WIDTH - 1) - {1'b0, tp[LV][0]};
        norm_d = s1_data_q << lzc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_st_q <= EMPTY;
            s2_st_q <= EMPTY;
        end else begin
            s1_st_q <= s1_st_d;
            s2_st_q <= s2_st_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_data_q <= in_data;
            s1_gv_q   <= gv_d;
            s1_gp_q   <= gp_d;
        end
        if (s1_adv) begin
            s2_pos_q  <= pos_d;
            s2_lzc_q  <= lzc_d;
            s2_zero_q <= zero_d;
            s2_norm_q <= norm_d;
        end
    end

    assign out_valid = (s2_st_q == FULL);
    assign out_pos   = out_valid ? s2_pos_q  : '0;
    assign out_lzc   = out_valid ? s2_lzc_q  : '0;
    assign out_zero  = out_valid ? s2_zero_q : 1'b0;
    assign out_norm  = out_valid ? s2_norm_q : '0;

endmodule

// File: tb/tb_fpu_lzd_pipe.sv
// Scoreboard bench for fpu_lzd_pipe: driver pushes reference results, monitor pops on each output transfer.
module tb_fpu_lzd_pipe;

    localparam int W  = 32;
    localparam int PW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_pos;
    logic [PW:0]   out_lzc;
    logic          out_zero;
    logic [W-1:0]  out_norm;

    always #5 clk = ~clk;

    fpu_lzd_pipe #(.WIDTH(W), .POS_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_lzc   (out_lzc),
        .out_zero  (out_zero),
        .out_norm  (out_norm)
    );

    typedef struct packed {
        logic [PW-1:0] pos;
        logic [PW:0]   lzc;
        logic          zero;
        logic [W-1:0]  norm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: scan from the MSB counting zeros, then shift by that count.
    function automatic exp_t ref_model(input logic [W-1:0] d);
        exp_t e;
        int   lz;
        lz = 0;
        while (lz < W && d[W-1-lz] == 1'b0) lz++;
        e.zero = (lz == W);
        e.lzc  = (PW+1)'(lz);
        e.pos  = e.zero ? '0 : PW'(W - 1 - lz);
        e.norm = (lz >= W) ? '0 : (d << lz);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic r, output logic fired);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        fired = 1'b0;
        if (r) sb.delete();
        else if (v && in_ready) begin
            sb.push_back(ref_model(d));
            fired = 1'b1;
        end
    endtask

    // Monitor: result transfers, output gating while idle, stability while stalled.
    exp_t held;
    logic held_valid = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (held_valid) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'({out_pos, out_lzc, out_zero, out_norm}), 64'(held));
        end
        held_valid = 1'b0;
        if (out_valid) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    check("result", 64'({out_pos, out_lzc, out_zero, out_norm}), 64'(sb.pop_front()));
                end
            end else if (!rst) begin
                held       = {out_pos, out_lzc, out_zero, out_norm};
                held_valid = 1'b1;
            end
        end else begin
            check("idle_outputs_zero", 64'({out_pos, out_lzc, out_zero, out_norm}), 64'd0);
        end
    end

    initial begin
        logic         f;
        int           cnt;
        logic [W-1:0] r, d;
        int           sh;

        step(1'b1, W'($urandom), 1'b0, 1'b1, f);
        step(1'b0, '0, 1'b0, 1'b1, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Latency and the directed operands.
        step(1'b1, 32'h0000_8000, 1'b1, 1'b0, f);
        check("lat_fire", 64'(f), 64'd1);
        step(1'b0, W'($urandom), 1'b1, 1'b0, f);
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        step(1'b0, W'($urandom), 1'b1, 1'b0, f);
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        check("lat_pos", 64'(out_pos), 64'd15);
        check("lat_lzc", 64'(out_lzc), 64'd16);
        check("lat_zero", 64'(out_zero), 64'd0);
        check("lat_norm", 64'(out_norm), 64'h8000_0000);

        step(1'b1, '0, 1'b1, 1'b0, f);
        step(1'b1, 32'h8000_0000, 1'b1, 1'b0, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        check("zero_flag", 64'(out_zero), 64'd1);
        check("zero_lzc", 64'(out_lzc), 64'd32);
        check("zero_pos", 64'(out_pos), 64'd0);
        check("zero_norm", 64'(out_norm), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, f);
        check("msb_pos", 64'(out_pos), 64'd31);
        check("msb_lzc", 64'(out_lzc), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, f);

        // Walking one, back to back; the last result must leave exactly two cycles after the last issue.
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            step(1'b1, W'(1) << i, 1'b1, 1'b0, f);
            cnt += int'(f);
        end
        check("walk_accepted", 64'(cnt), 64'(W));
        step(1'b0, '0, 1'b1, 1'b0, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        check("walk_no_bubbles", 64'(sb.size()), 64'd0);

        // Output stall with continuous input: exactly two operands fit.
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'($urandom), 1'b0, 1'b0, f);
            cnt += int'(f);
        end
        check("stall_accepted", 64'(cnt), 64'd2);
        for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b1, 1'b0, f);
        for (int i = 0; i < 10; i++) step(1'b0, W'($urandom), 1'($urandom_range(0, 1)), 1'b0, f);

        // Reset with both stages full; in-flight operands and the reset-cycle transfer vanish.
        for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, f);
        step(1'b1, 32'h0000_DEAD, 1'b0, 1'b1, f);
        step(1'b0, W'($urandom), 1'b1, 1'b0, f);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 32'h0000_0001, 1'b1, 1'b0, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        check("post_reset_valid", 64'(out_valid), 64'd1);
        check("post_reset_pos", 64'(out_pos), 64'd0);
        check("post_reset_lzc", 64'(out_lzc), 64'd31);

        // Random traffic with random back-pressure and rare resets.
        for (int i = 0; i < 4000; i++) begin
            r  = W'($urandom);
            sh = $urandom_range(0, W);
            d  = (sh == W) ? '0 : (r >> sh);
            if ($urandom_range(0, 499) == 0)
                step(1'b1, d, 1'b0, 1'b1, f);
            else
                step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 3) != 0), 1'b0, f);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, f);
        step(1'b0, '0, 1'b1, 1'b0, f);
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_lzd_pipe.md
FPU_LZD_PIPE -- requirements
Module: fpu_lzd_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; SHALL be a power of two in 4..64 (elaboration error otherwise).
REQ-002 Parameter: POS_W, default $clog2(WIDTH), width of position/count outputs.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand present.
REQ-006 Port: in_ready  output  1  block accepts operand this cycle.
REQ-007 Port: in_data  input  WIDTH  operand to scan (bit WIDTH-1 = MSB).
REQ-008 Port: out_valid  output  1  result present.
REQ-009 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-010 Port: out_pos  output  POS_W  bit index of leading 1.
REQ-011 Port: out_lzc  output  POS_W+1  leading-zero count, 0..WIDTH.
REQ-012 Port: out_zero  output  1  operand was all zeros.
REQ-013 Port: out_norm  output  WIDTH  operand left-shifted by out_lzc (MSB = 1 unless zero).

Function
REQ-014 Transfer occurs on a cycle where valid and ready are both 1; input side and output side independent.
REQ-015 Two pipeline stages: S1 registers in_data plus per-4-bit-group valid flags and 2-bit local positions; S2 registers the merged tree result (pairwise mux of halves, upper half prioritised), lzc and shifted mantissa.
REQ-016 Latency exactly 2 cycles from input transfer to out_valid=1 when out_ready held 1.
REQ-017 Throughput one operand per cycle while out_ready=1.
REQ-018 Stall: when out_valid=1 and out_ready=0, S2 holds all outputs stable; S1 advances into S2 only when S2 is empty or draining.
REQ-019 in_ready = !S1_full || S2 can accept (S2 empty or out_ready=1); combinational from out_ready, no other input.
REQ-020 Per-stage state: EMPTY -> FULL on load; FULL -> EMPTY on advance without reload; FULL -> FULL on simultaneous advance and reload.
REQ-021 Simultaneous input and output transfer with both stages full SHALL lose no data and duplicate no result.
REQ-022 Results SHALL leave in input order.
REQ-023 Non-zero operand: out_pos = index of highest set bit; out_lzc = WIDTH-1-out_pos; out_zero = 0.
REQ-024 Zero operand: out_zero = 1, out_pos = 0 (gated to zero), out_lzc = WIDTH, out_norm = 0.
REQ-025 out_norm = in_data << out_lzc, truncated to WIDTH bits; bit WIDTH-1 = 1 for non-zero operands.
REQ-026 When out_valid=0, out_pos/out_lzc/out_zero/out_norm SHALL be 0.
REQ-027 in_data ignored when in_valid=0 or in_ready=0.

Reset
REQ-028 rst=1 at a clock edge empties both stages: out_valid=0, all data outputs 0, in_ready=1 on the following cycle.
REQ-029 Reset mid-operation discards in-flight operands; no result for them ever appears.
REQ-030 Transfer attempted in the reset cycle SHALL be dropped.

Verification
REQ-031 WIDTH=32, in_data=0x0000_8000, out_ready=1 -> 2 cycles later out_pos=15, out_lzc=16, out_zero=0, out_norm=0x8000_0000.
REQ-032 WIDTH=32, in_data=0 -> out_zero=1, out_pos=0, out_lzc=32, out_norm=0; in_data=0x8000_0000 -> out_pos=31, out_lzc=0.
REQ-033 Back-to-back 0x1, 0x2, 0x4, ... 0x8000_0000 with out_ready=1 -> out_pos 0..31 on 32 consecutive cycles, no bubbles.
REQ-034 out_ready=0 for 5 cycles with continuous in_valid -> in_ready falls after 2 accepted operands; outputs stable; on release, results drain in order with none lost.
REQ-035 Reset asserted while both stages full -> next cycle out_valid=0, in_ready=1; first post-reset operand 0x0000_0001 yields out_pos=0, out_lzc=31.
REQ-036 WIDTH=16 and WIDTH=64 builds: random operands vs reference count model, 10k vectors each, plus all single-bit operands.
